// File: rtl/xspi_cmd_pkg.sv
// Shared definitions for the xSPI NOR command sequencer.
// Holds opcodes, PHY lane-mode encodings, the sequencer state type,
// the per-opcode phase descriptor and the opcode decoder.
package xspi_cmd_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_FAST = 8'h0B;
   localparam logic [7:0] OP_QOUT = 8'h6B;
   localparam logic [7:0] OP_QIO  = 8'hEB;
   localparam logic [7:0] OP_PP   = 8'h02;
   localparam logic [7:0] OP_RDID = 8'h9F;

   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_DUAL   = 2'b01;
   localparam logic [1:0] MODE_QUAD   = 2'b10;
   localparam logic [1:0] MODE_OCTO   = 2'b11;

   localparam int DUMMY_BITS = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DUMMY,
      S_DRD,
      S_DWR,
      S_DRAIN
   } state_t;

   // valid = 0 marks an opcode that is not in the table
   typedef struct packed {
      logic [1:0]            addr_mode;
      logic [DUMMY_BITS-1:0] dummy;
      logic [1:0]            data_mode;
      logic                  is_write;
      logic                  has_addr;
      logic                  valid;
   } cmd_desc_t;

   function automatic cmd_desc_t decode_cmd(input logic [7:0] op);
      cmd_desc_t d;
      d = '0;
      case (op)
         OP_READ: d = '{MODE_SINGLE, 6'd0, MODE_SINGLE, 1'b0, 1'b1, 1'b1};
         OP_FAST: d = '{MODE_SINGLE, 6'd8, MODE_SINGLE, 1'b0, 1'b1, 1'b1};
         OP_QOUT: d = '{MODE_SINGLE, 6'd8, MODE_QUAD,   1'b0, 1'b1, 1'b1};
         OP_QIO:  d = '{MODE_QUAD,   6'd4, MODE_QUAD,   1'b0, 1'b1, 1'b1};
         OP_PP:   d = '{MODE_SINGLE, 6'd0, MODE_SINGLE, 1'b1, 1'b1, 1'b1};
         OP_RDID: d = '{MODE_SINGLE, 6'd0, MODE_SINGLE, 1'b0, 1'b0, 1'b1};
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/xspi_sync2.sv
// Two-flop synchroniser for a single-bit level crossing into clk_i.
// Latency: 2 clk. No backpressure.
// Ports: clk_i/rst_i (sync, active high), i_d async level in, o_q synced out.
module xspi_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/xspi_cmd_seq.sv
// xSPI NOR command sequencer: decodes the opcode and programs the PHY for
// ADDR/DUMMY/DATA phases, bridging data words to a word-wide memory port.
// Latency: phase params registered 1 clk after the synced txndone rising edge
// (read data reaches txntx_o 1 clk after mem_rvalid_i). No backpressure: a
// read word missing at its done edge is sent as all-ones and flagged on err_o.
// Ports: PHY side txndone_i/txnrx_i in, txnbc_o/txnmode_o/txndir_o/txntx_o out;
// memory side mem_addr_o/mem_rd_o/mem_wr_o/mem_wdata_o out, mem_rdata_i/mem_rvalid_i in;
// status busy_o/err_o; sce_i chip enable (async), clk_i/rst_i (sync, active high).
module xspi_cmd_seq
   import xspi_cmd_pkg::*;
#(
   parameter int              WORD_SIZE        = 32,
   parameter int              CYCLE_COUNT_BITS = 6,
   parameter int              ADDR_BITS        = 24,
   parameter logic [23:0]     ID_VALUE         = 24'h0000A5
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        sce_i,
   input  logic                        txndone_i,
   input  logic [WORD_SIZE-1:0]        txnrx_i,
   output logic [CYCLE_COUNT_BITS-1:0] txnbc_o,
   output logic [1:0]                  txnmode_o,
   output logic                        txndir_o,
   output logic [WORD_SIZE-1:0]        txntx_o,
   output logic [ADDR_BITS-1:0]        mem_addr_o,
   output logic                        mem_rd_o,
   input  logic [WORD_SIZE-1:0]        mem_rdata_i,
   input  logic                        mem_rvalid_i,
   output logic                        mem_wr_o,
   output logic [WORD_SIZE-1:0]        mem_wdata_o,
   output logic                        busy_o,
   output logic                        err_o
);

   localparam logic [CYCLE_COUNT_BITS-1:0] BC_CMD  = CYCLE_COUNT_BITS'(8);
   localparam logic [CYCLE_COUNT_BITS-1:0] BC_ADDR = CYCLE_COUNT_BITS'(ADDR_BITS);
   localparam logic [CYCLE_COUNT_BITS-1:0] BC_WORD = CYCLE_COUNT_BITS'(WORD_SIZE);
   localparam logic [CYCLE_COUNT_BITS-1:0] BC_ID   = CYCLE_COUNT_BITS'(24);
   localparam logic [ADDR_BITS-1:0]        A_STEP  = ADDR_BITS'(WORD_SIZE / 8);

   logic      w_sce_s;
   logic      w_done_s;
   logic      w_done_evt;
   logic      w_rv;
   cmd_desc_t w_dec;

   logic                        r_done_d;
   state_t                      r_state;
   logic [DUMMY_BITS-1:0]       r_dummy;
   logic [1:0]                  r_data_mode;
   logic                        r_is_write;
   logic                        r_rdid;
   logic                        r_pend;     // read requested, data not yet returned
   logic [WORD_SIZE-1:0]        r_hold;
   logic [CYCLE_COUNT_BITS-1:0] r_txnbc;
   logic [1:0]                  r_txnmode;
   logic                        r_txndir;
   logic [WORD_SIZE-1:0]        r_txntx;
   logic [ADDR_BITS-1:0]        r_mem_addr;
   logic                        r_mem_rd;
   logic                        r_mem_wr;
   logic [WORD_SIZE-1:0]        r_mem_wdata;
   logic                        r_err;

   xspi_sync2 u_sync_sce  (.clk_i(clk_i), .rst_i(rst_i), .i_d(sce_i),     .o_q(w_sce_s));
   xspi_sync2 u_sync_done (.clk_i(clk_i), .rst_i(rst_i), .i_d(txndone_i), .o_q(w_done_s));

   assign w_done_evt = w_done_s & ~r_done_d;
   assign w_dec      = decode_cmd(txnrx_i[7:0]);
   // rvalid only counts against an outstanding request; stale returns are dropped
   assign w_rv       = mem_rvalid_i & r_pend;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_done_d <= 1'b0;
      else       r_done_d <= w_done_s;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !w_sce_s) begin
         r_state     <= S_IDLE;
         r_dummy     <= '0;
         r_data_mode <= MODE_SINGLE;
         r_is_write  <= 1'b0;
         r_rdid      <= 1'b0;
         r_pend      <= 1'b0;
         r_hold      <= '1;
         r_txnbc     <= BC_CMD;
         r_txnmode   <= MODE_SINGLE;
         r_txndir    <= 1'b0;
         r_txntx     <= '1;
         r_mem_addr  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= '0;
         r_err       <= 1'b0;
      end else begin
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
         r_err    <= 1'b0;
         if (w_rv) begin
            r_hold <= mem_rdata_i;
            r_pend <= 1'b0;
         end
         // writes present the current address with the pulse, then step
         if (r_mem_wr) r_mem_addr <= r_mem_addr + A_STEP;
         if (r_state == S_DRD && !r_rdid) r_txntx <= w_rv ? mem_rdata_i : r_hold;

         if (w_done_evt) begin
            case (r_state)
               S_IDLE: begin
                  r_dummy     <= w_dec.dummy;
                  r_data_mode <= w_dec.data_mode;
                  r_is_write  <= w_dec.is_write;
                  if (!w_dec.valid) begin
                     r_err   <= 1'b1;
                     r_state <= S_DRAIN;
                  end else if (!w_dec.has_addr) begin
                     r_rdid    <= 1'b1;
                     r_state   <= S_DRD;
                     r_txnbc   <= BC_ID;
                     r_txnmode <= MODE_SINGLE;
                     r_txndir  <= 1'b1;
                     r_txntx   <= WORD_SIZE'(ID_VALUE);
                  end else begin
                     r_state   <= S_ADDR;
                     r_txnbc   <= BC_ADDR;
                     r_txnmode <= w_dec.addr_mode;
                     r_txndir  <= 1'b0;
                  end
               end
               S_ADDR: begin
                  r_mem_addr <= txnrx_i[ADDR_BITS-1:0];
                  if (!r_is_write) begin
                     r_mem_rd <= 1'b1;
                     r_pend   <= 1'b1;
                     r_hold   <= '1;
                  end
                  if (r_dummy != '0) begin
                     r_state   <= S_DUMMY;
                     r_txnbc   <= CYCLE_COUNT_BITS'(r_dummy);
                     r_txnmode <= MODE_SINGLE;
                     r_txndir  <= 1'b0;
                  end else begin
                     r_state   <= r_is_write ? S_DWR : S_DRD;
                     r_txnbc   <= BC_WORD;
                     r_txnmode <= r_data_mode;
                     r_txndir  <= ~r_is_write;
                  end
               end
               S_DUMMY: begin
                  r_state   <= r_is_write ? S_DWR : S_DRD;
                  r_txnbc   <= BC_WORD;
                  r_txnmode <= r_data_mode;
                  r_txndir  <= ~r_is_write;
               end
               S_DRD: begin
                  if (r_rdid) begin
                     r_rdid    <= 1'b0;
                     r_state   <= S_DRAIN;
                     r_txnbc   <= BC_CMD;
                     r_txnmode <= MODE_SINGLE;
                     r_txndir  <= 1'b0;
                     r_txntx   <= '1;
                  end else begin
                     if (r_pend && !mem_rvalid_i) r_err <= 1'b1;
                     // data arriving on the done edge belongs to the next word
                     r_hold     <= w_rv ? mem_rdata_i : '1;
                     r_mem_addr <= r_mem_addr + A_STEP;
                     r_mem_rd   <= 1'b1;
                     r_pend     <= 1'b1;
                  end
               end
               S_DWR: begin
                  r_mem_wr    <= 1'b1;
                  r_mem_wdata <= txnrx_i;
               end
               S_DRAIN: begin
               end
               default: r_state <= S_DRAIN;
            endcase
         end
      end
   end

   assign txnbc_o     = r_txnbc;
   assign txnmode_o   = r_txnmode;
   assign txndir_o    = r_txndir;
   assign txntx_o     = r_txntx;
   assign mem_addr_o  = r_mem_addr;
   assign mem_rd_o    = r_mem_rd;
   assign mem_wr_o    = r_mem_wr;
   assign mem_wdata_o = r_mem_wdata;
   assign busy_o      = (r_state != S_IDLE);
   assign err_o       = r_err;

endmodule
